// File: rtl/cache_arbiter_pkg.sv
// Shared types for the cache-to-memory arbiter.
// Contents:
//   DEFAULT_LINE_W : default cache-line width in bits
//   arb_state_t    : arbiter FSM state (legacy-compatible 2-bit encoding)
//   arb_owner_t    : which cache owns (or wins) the memory port
package cache_arbiter_pkg;

  localparam int DEFAULT_LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one physical-memory port between the instruction
// cache and the data cache. One requester is granted at a time; its address,
// write data and command are latched for the whole transaction, and the
// completion pulse is routed only to the owner.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_read, i_address        instruction line-read request
//   i_rdata, i_resp          line data / completion to instruction cache
//   d_read, d_write          data line-read / writeback request
//   d_address, d_wdata       data line address / writeback data
//   d_rdata, d_resp          line data / completion to data cache
//   pmem_read, pmem_write    command to physical memory (from latch)
//   pmem_address, pmem_wdata latched address / write data
//   pmem_rdata, pmem_resp    memory read data / one-cycle done pulse
//
// Handshake: a request (i_read, d_read or d_write) is a level that is
// sampled only while the arbiter is IDLE; the grant is implicit and the
// command appears on pmem the next cycle. x_resp is a one-cycle pulse that
// coincides with pmem_resp and completes the transaction; x_rdata is valid
// only in that cycle. Requesters drop their request by the cycle after
// x_resp, otherwise it is taken as a new request.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 4,
  parameter int LINE_W       = DEFAULT_LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [31:0]       i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  arb_state_t        state;
  logic [SW-1:0]     streak;
  logic [31:0]       addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              cmd_read;
  logic              cmd_write;

  logic              d_req;
  logic              any_req;
  arb_owner_t        winner;
  logic              busy;

  // Data side wins ties unless it has already taken MAX_D_STREAK grants in
  // a row while an instruction fetch was waiting.
  always_comb begin
    d_req   = d_read | d_write;
    any_req = d_req | i_read;
    winner  = OWN_I;
    if (d_req && !(i_read && (streak == STREAK_MAX))) begin
      winner = OWN_D;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      streak    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cmd_read  <= 1'b0;
      cmd_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // No fetch waiting means no starvation to track.
          if (!i_read) begin
            streak <= '0;
          end
          if (any_req) begin
            if (winner == OWN_D) begin
              state     <= BUSY_D;
              addr_q    <= d_address;
              // Read and write together is illegal; treat it as a write.
              cmd_write <= d_write;
              cmd_read  <= ~d_write;
              wdata_q   <= d_write ? d_wdata : '0;
              if (i_read && (streak != STREAK_MAX)) begin
                streak <= streak + 1'b1;
              end
            end else begin
              state     <= BUSY_I;
              addr_q    <= i_address;
              cmd_write <= 1'b0;
              cmd_read  <= 1'b1;
              wdata_q   <= '0;
              streak    <= '0;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (pmem_resp) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The latched command is only presented while a transaction is open, so
  // it drops in the same cycle the FSM returns to IDLE (including on reset).
  assign busy         = (state != IDLE);
  assign pmem_read    = busy & cmd_read;
  assign pmem_write   = busy & cmd_write;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  assign i_resp  = (state == BUSY_I) & pmem_resp;
  assign d_resp  = (state == BUSY_D) & pmem_resp;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule
